// File: rtl/dwc_pkg.sv
// Shared types, default geometry and sizing helper for the frame-aware width converter.
// Default geometry: 4-bit elements, 3 -> 5 elements per beat, 12-element frames.
package dwc_pkg;

   localparam int DEF_AW          = 4;
   localparam int DEF_IN_FOLD     = 3;
   localparam int DEF_OUT_FOLD    = 5;
   localparam int DEF_FRAME_ELEMS = 12;

   typedef logic [DEF_AW-1:0] elem_t;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   localparam int CAP       = DEF_IN_FOLD + DEF_OUT_FOLD;
   localparam int IN_BEATS  = DEF_FRAME_ELEMS / DEF_IN_FOLD;
   localparam int OUT_BEATS = ceil_div(DEF_FRAME_ELEMS, DEF_OUT_FOLD);

endpackage

// File: rtl/dwc_elem_buffer.sv
// Element shift buffer: pops OUT_FOLD elements off the bottom, writes IN_FOLD elements at wr_idx.
// Update takes effect at the next clock edge; wr_idx is the post-pop fill level, supplied by the owner.
module dwc_elem_buffer
   import dwc_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int IN_FOLD  = DEF_IN_FOLD,
   parameter int OUT_FOLD = DEF_OUT_FOLD,
   parameter int DEPTH    = DEF_IN_FOLD + DEF_OUT_FOLD,
   parameter int IDX_W    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pop,
   input  logic                   push,
   input  logic [IDX_W-1:0]       wr_idx,
   input  logic [IN_FOLD*AW-1:0]  wr_data,
   output logic [OUT_FOLD*AW-1:0] rd_data
);

   logic [DEPTH*AW-1:0] mem;
   logic [DEPTH*AW-1:0] mem_nxt;

   always_comb begin
      mem_nxt = mem;
      if (pop) begin
         mem_nxt = mem >> (OUT_FOLD * AW);
      end
      if (push) begin
         for (int k = 0; k < IN_FOLD; k++) begin
            if (int'(wr_idx) + k < DEPTH) begin
               mem_nxt[(int'(wr_idx) + k) * AW +: AW] = wr_data[k * AW +: AW];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem <= '0;
      end else begin
         mem <= mem_nxt;
      end
   end

   assign rd_data = mem[OUT_FOLD*AW-1:0];

endmodule

// File: rtl/dwc_frame_ratio.sv
// AXI-Stream IN_FOLD:OUT_FOLD element repacker with per-frame tlast and zero-padded tail beat.
// One cycle from input accept to output visibility; input stalls while a frame tail drains.
module dwc_frame_ratio
   import dwc_pkg::*;
#(
   parameter int ACTIVATION_WIDTH = DEF_AW,
   parameter int IN_FOLD          = DEF_IN_FOLD,
   parameter int OUT_FOLD         = DEF_OUT_FOLD,
   parameter int FRAME_ELEMS      = DEF_FRAME_ELEMS,
   localparam int IN_W            = ACTIVATION_WIDTH * IN_FOLD,
   localparam int OUT_W           = ACTIVATION_WIDTH * OUT_FOLD,
   localparam int IN_BW           = (IN_W + 7) / 8 * 8,
   localparam int OUT_BW          = (OUT_W + 7) / 8 * 8
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic [IN_BW-1:0]  s_axis_input_tdata,
   input  logic              s_axis_input_tvalid,
   output logic              s_axis_input_tready,
   output logic [OUT_BW-1:0] m_axis_output_tdata,
   output logic              m_axis_output_tvalid,
   input  logic              m_axis_output_tready,
   output logic              m_axis_output_tlast
);

   localparam int BUF_CAP   = IN_FOLD + OUT_FOLD;
   localparam int FR_BEATS  = FRAME_ELEMS / IN_FOLD;
   localparam int CNT_W     = $clog2(BUF_CAP + 1);
   localparam int IB_W      = (FR_BEATS > 1) ? $clog2(FR_BEATS) : 1;
   localparam logic [CNT_W-1:0] OF_C    = CNT_W'(OUT_FOLD);
   localparam logic [CNT_W-1:0] IF_C    = CNT_W'(IN_FOLD);
   localparam logic [IB_W-1:0]  LAST_IB = IB_W'(FR_BEATS - 1);

   if (FRAME_ELEMS % IN_FOLD != 0) begin : g_bad_frame
      $error("FRAME_ELEMS must be a multiple of IN_FOLD");
   end

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_pop;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [IB_W-1:0]   ibeat;
   logic              tail;
   logic              pop;
   logic              push;
   logic [OUT_W-1:0]  rd_data;

   // Admitting only at cnt<=OUT_FOLD keeps a full IN_FOLD write in range even without a pop.
   assign s_axis_input_tready  = !ap_rst && !tail && (cnt <= OF_C);
   assign m_axis_output_tvalid = (cnt >= OF_C) || (tail && (cnt != '0));
   assign m_axis_output_tlast  = tail && (cnt <= OF_C);

   assign pop  = m_axis_output_tvalid && m_axis_output_tready;
   assign push = s_axis_input_tvalid && s_axis_input_tready;

   always_comb begin
      cnt_pop = cnt;
      if (pop) begin
         cnt_pop = (cnt >= OF_C) ? cnt - OF_C : '0;
      end
      cnt_nxt = push ? cnt_pop + IF_C : cnt_pop;
   end

   always_comb begin
      m_axis_output_tdata = '0;
      for (int k = 0; k < OUT_FOLD; k++) begin
         if (k < int'(cnt)) begin
            m_axis_output_tdata[k*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] =
               rd_data[k*ACTIVATION_WIDTH +: ACTIVATION_WIDTH];
         end
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         cnt   <= '0;
         ibeat <= '0;
         tail  <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (push) begin
            if (ibeat == LAST_IB) begin
               ibeat <= '0;
               tail  <= 1'b1;
            end else begin
               ibeat <= ibeat + IB_W'(1);
            end
         end else if (pop && m_axis_output_tlast) begin
            tail <= 1'b0;
         end
      end
   end

   dwc_elem_buffer #(
      .AW       (ACTIVATION_WIDTH),
      .IN_FOLD  (IN_FOLD),
      .OUT_FOLD (OUT_FOLD),
      .DEPTH    (BUF_CAP),
      .IDX_W    (CNT_W)
   ) u_buf (
      .clk     (ap_clk),
      .rst     (ap_rst),
      .pop     (pop),
      .push    (push),
      .wr_idx  (cnt_pop),
      .wr_data (s_axis_input_tdata[IN_W-1:0]),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_dwc_frame_ratio.sv
// Directed and randomized checks of dwc_frame_ratio across four element geometries.
module tb_dwc_frame_ratio;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // A: 4-bit, 3 -> 5, frame 12
   logic [15:0] a_sd; logic a_sv, a_sr; logic [23:0] a_md; logic a_mv, a_mr, a_ml;
   // B: 4-bit, 10 -> 2, frame 10
   logic [39:0] b_sd; logic b_sv, b_sr; logic [7:0]  b_md; logic b_mv, b_mr, b_ml;
   // C: 4-bit, 2 -> 10, frame 10
   logic [7:0]  c_sd; logic c_sv, c_sr; logic [39:0] c_md; logic c_mv, c_mr, c_ml;
   // D: 3-bit, 4 -> 3, frame 12
   logic [15:0] d_sd; logic d_sv, d_sr; logic [15:0] d_md; logic d_mv, d_mr, d_ml;

   dwc_frame_ratio #(.ACTIVATION_WIDTH(4), .IN_FOLD(3), .OUT_FOLD(5), .FRAME_ELEMS(12)) u_a (
      .ap_clk(clk), .ap_rst(rst),
      .s_axis_input_tdata(a_sd), .s_axis_input_tvalid(a_sv), .s_axis_input_tready(a_sr),
      .m_axis_output_tdata(a_md), .m_axis_output_tvalid(a_mv), .m_axis_output_tready(a_mr),
      .m_axis_output_tlast(a_ml));
   dwc_frame_ratio #(.ACTIVATION_WIDTH(4), .IN_FOLD(10), .OUT_FOLD(2), .FRAME_ELEMS(10)) u_b (
      .ap_clk(clk), .ap_rst(rst),
      .s_axis_input_tdata(b_sd), .s_axis_input_tvalid(b_sv), .s_axis_input_tready(b_sr),
      .m_axis_output_tdata(b_md), .m_axis_output_tvalid(b_mv), .m_axis_output_tready(b_mr),
      .m_axis_output_tlast(b_ml));
   dwc_frame_ratio #(.ACTIVATION_WIDTH(4), .IN_FOLD(2), .OUT_FOLD(10), .FRAME_ELEMS(10)) u_c (
      .ap_clk(clk), .ap_rst(rst),
      .s_axis_input_tdata(c_sd), .s_axis_input_tvalid(c_sv), .s_axis_input_tready(c_sr),
      .m_axis_output_tdata(c_md), .m_axis_output_tvalid(c_mv), .m_axis_output_tready(c_mr),
      .m_axis_output_tlast(c_ml));
   dwc_frame_ratio #(.ACTIVATION_WIDTH(3), .IN_FOLD(4), .OUT_FOLD(3), .FRAME_ELEMS(12)) u_d (
      .ap_clk(clk), .ap_rst(rst),
      .s_axis_input_tdata(d_sd), .s_axis_input_tvalid(d_sv), .s_axis_input_tready(d_sr),
      .m_axis_output_tdata(d_md), .m_axis_output_tvalid(d_mv), .m_axis_output_tready(d_mr),
      .m_axis_output_tlast(d_ml));

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        vld;
      logic [15:0] dat;
      logic        rdy;
      logic        e_tv;
      logic        e_tr;
      logic [23:0] e_td;
      logic        e_tl;
   } vec_t;

   vec_t tab[10];

   // Random frames through config A with a scoreboard and a hold-while-stalled check.
   task automatic run_a(input int nframes, input int pv, input int pr);
      logic [11:0] in_q[$];
      logic [24:0] exp_q[$];
      logic [3:0]  el[12];
      logic [23:0] d;
      logic [24:0] prev;
      logic        pst;
      logic        acc;
      int          budget;
      for (int f = 0; f < nframes; f++) begin
         for (int i = 0; i < 12; i++) el[i] = 4'($urandom_range(0, 15));
         for (int b = 0; b < 4; b++) in_q.push_back({el[3*b+2], el[3*b+1], el[3*b]});
         for (int o = 0; o < 3; o++) begin
            d = '0;
            for (int k = 0; k < 5; k++) if (5*o + k < 12) d[4*k +: 4] = el[5*o + k];
            exp_q.push_back({(o == 2), d});
         end
      end
      pst = 1'b0; acc = 1'b0; prev = '0;
      budget = nframes * 60 + 100;
      while (exp_q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
         if (pst) begin
            chk("stall tvalid held", a_mv, 1);
            chk("stall beat held", {a_ml, a_md}, prev);
         end
         a_mr = ($urandom_range(0, 99) < pr);
         if (a_mv && a_mr) chk("scoreboard beat", {a_ml, a_md}, exp_q.pop_front());
         pst  = a_mv && !a_mr;
         prev = {a_ml, a_md};
         if (acc) void'(in_q.pop_front());
         if (!(a_sv && !acc)) begin
            if (in_q.size() > 0) begin
               a_sv = ($urandom_range(0, 99) < pv);
               a_sd = {4'($urandom_range(0, 15)), in_q[0]};
            end else begin
               a_sv = 1'b0;
               a_sd = 16'($urandom_range(0, 65535));
            end
         end
         acc = a_sv && a_sr;
      end
      chk("scoreboard drained", exp_q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] b_exp[5];
      logic [7:0]  c_in[5];
      logic [15:0] d_in[3];
      logic [16:0] d_exp[4];
      int          ni, no;
      logic        acc;

      b_exp = '{40'h10, 40'h32, 40'h54, 40'h76, 40'h98};
      c_in  = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98};
      d_in  = '{16'hF688, 16'hFFAC, 16'hF688};
      d_exp = '{{1'b0, 16'h0088}, {1'b0, 16'h0163}, {1'b0, 16'h003E}, {1'b1, 16'h00D1}};

      //          vld   dat       rdy   tv    tr    td         tl
      tab[0] = '{1'b1, 16'hF210, 1'b1, 1'b0, 1'b1, 24'h00000, 1'b0};
      tab[1] = '{1'b1, 16'hA543, 1'b1, 1'b0, 1'b1, 24'h00210, 1'b0};
      tab[2] = '{1'b1, 16'h5876, 1'b1, 1'b1, 1'b0, 24'h43210, 1'b0};
      tab[3] = '{1'b1, 16'h5876, 1'b1, 1'b0, 1'b1, 24'h00005, 1'b0};
      tab[4] = '{1'b1, 16'hFBA9, 1'b1, 1'b0, 1'b1, 24'h08765, 1'b0};
      tab[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 24'h98765, 1'b0};
      tab[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 24'h98765, 1'b0};
      tab[7] = '{1'b1, 16'h0210, 1'b0, 1'b1, 1'b0, 24'h000BA, 1'b1};
      tab[8] = '{1'b1, 16'h0210, 1'b1, 1'b1, 1'b0, 24'h000BA, 1'b1};
      tab[9] = '{1'b0, 16'h0210, 1'b0, 1'b0, 1'b1, 24'h00000, 1'b0};

      rst = 1'b1;
      a_sd = '0; a_sv = 0; a_mr = 0;
      b_sd = '0; b_sv = 0; b_mr = 0;
      c_sd = '0; c_sv = 0; c_mr = 0;
      d_sd = '0; d_sv = 0; d_mr = 0;
      repeat (2) @(negedge clk);
      chk("reset a tready", a_sr, 0);
      chk("reset a tvalid", a_mv, 0);
      chk("reset a tlast", a_ml, 0);
      chk("reset a tdata", a_md, 0);
      chk("reset b tready", b_sr, 0);
      chk("reset c tvalid", c_mv, 0);
      rst = 1'b0;

      // C: five narrow beats merge into one wide beat
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         c_sv = 1'b1; c_sd = c_in[i]; c_mr = 1'b1;
         #1;
         chk($sformatf("c in%0d tready", i), c_sr, 1);
         chk($sformatf("c in%0d tvalid", i), c_mv, 0);
      end
      @(negedge clk);
      c_sv = 1'b0;
      #1;
      chk("c out tvalid", c_mv, 1);
      chk("c out tdata", c_md, 40'h9876543210);
      chk("c out tlast", c_ml, 1);
      @(negedge clk);
      #1;
      chk("c drained", c_mv, 0);

      // D: odd element width, garbage in input pad bits, output pad must be zero
      ni = 0; no = 0; acc = 1'b0; d_mr = 1'b1;
      for (int cyc = 0; cyc < 40 && no < 4; cyc++) begin
         @(negedge clk);
         if (acc) ni++;
         if (ni < 3) begin
            d_sv = 1'b1; d_sd = d_in[ni];
         end else begin
            d_sv = 1'b0; d_sd = 16'hFFFF;
         end
         if (d_mv) begin
            chk($sformatf("d beat%0d", no), {d_ml, d_md}, d_exp[no]);
            no++;
         end
         acc = d_sv && d_sr;
      end
      chk("d beat count", no, 4);

      // B: one wide beat splits into five, next frame follows the tail pop
      @(negedge clk);
      b_sv = 1'b1; b_sd = 40'h9876543210; b_mr = 1'b1;
      #1;
      chk("b accept tready", b_sr, 1);
      @(negedge clk);
      b_sd = 40'hFEDCBA9876;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("b beat%0d tvalid", i), b_mv, 1);
         chk($sformatf("b beat%0d tdata", i), b_md, b_exp[i]);
         chk($sformatf("b beat%0d tlast", i), b_ml, (i == 4));
         chk($sformatf("b beat%0d tready", i), b_sr, 0);
         @(negedge clk);
      end
      #1;
      chk("b next frame tready", b_sr, 1);
      chk("b gap tvalid", b_mv, 0);
      @(negedge clk);
      b_sv = 1'b0;
      #1;
      chk("b frame2 tvalid", b_mv, 1);
      chk("b frame2 tdata", b_md, 8'h76);

      // A: cycle-accurate table for a 3 -> 5 frame with backpressure on tail
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         a_sv = tab[i].vld; a_sd = tab[i].dat; a_mr = tab[i].rdy;
         #1;
         chk($sformatf("t[%0d] tvalid", i), a_mv, tab[i].e_tv);
         chk($sformatf("t[%0d] tready", i), a_sr, tab[i].e_tr);
         chk($sformatf("t[%0d] tdata", i), a_md, tab[i].e_td);
         chk($sformatf("t[%0d] tlast", i), a_ml, tab[i].e_tl);
      end

      // A: reset mid-frame discards two buffered beats
      @(negedge clk);
      a_sv = 1'b1; a_sd = 16'h0210; a_mr = 1'b0;
      @(negedge clk);
      a_sd = 16'h0543;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid rst tvalid", a_mv, 0);
      chk("mid rst tready", a_sr, 0);
      chk("mid rst tdata", a_md, 0);
      chk("mid rst tlast", a_ml, 0);
      @(negedge clk);
      #1;
      chk("mid rst tvalid 2", a_mv, 0);
      chk("mid rst tready 2", a_sr, 0);
      @(negedge clk);
      rst = 1'b0; a_sv = 1'b0;
      run_a(1, 100, 100);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a_mr = 1'b0; a_sv = 1'b0;
         #1;
         chk("post-reset idle tvalid", a_mv, 0);
      end

      // A: random valid/ready traffic
      run_a(200, 50, 40);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
